// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Multiplies take MUL_CYCLES cycles; divides run 32 restoring steps plus a sign-fix cycle.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MDStart,
  input  logic [2:0]  EX_MDOp,
  input  logic [31:0] EX_RSData,
  input  logic [31:0] EX_RTData,
  input  logic        MD_flush,
  output logic        isbusy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;        // multiplicand, or raw dividend kept for divide-by-zero
  logic [31:0] b_q, b_d;        // multiplier, or divisor magnitude
  logic [32:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        accept_s;
  logic        is_mul_s;
  logic        is_div_s;
  logic [31:0] rs_abs_s;
  logic [31:0] rt_abs_s;
  logic [63:0] prod_s;
  logic [33:0] shift_s;
  logic [32:0] diff_s;
  logic        ge_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;

  assign accept_s = EX_MDStart && (state_q == S_IDLE) && !MD_flush &&
                    (EX_MDOp != OP_NONE) && (EX_MDOp != OP_RSVD);
  assign is_mul_s = (EX_MDOp == OP_MULT) || (EX_MDOp == OP_MULTU);
  assign is_div_s = (EX_MDOp == OP_DIV) || (EX_MDOp == OP_DIVU);
  assign rs_abs_s = ((EX_MDOp == OP_DIV) && EX_RSData[31]) ? (32'd0 - EX_RSData) : EX_RSData;
  assign rt_abs_s = ((EX_MDOp == OP_DIV) && EX_RTData[31]) ? (32'd0 - EX_RTData) : EX_RTData;

  // One 64x64 multiplier serves both flavours: sign-extend only for MULT.
  assign prod_s = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

  assign shift_s    = {rem_q, quot_q[31]};
  assign ge_s       = (shift_s >= {2'b00, b_q});
  assign diff_s     = shift_s[32:0] - {1'b0, b_q};
  assign quot_fix_s = qneg_q ? (32'd0 - quot_q) : quot_q;
  assign rem_fix_s  = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 33'd0;
      quot_q  <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: a flush returns any in-flight operation straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_d = S_MUL;
        end else if (accept_s && is_div_s) begin
          state_d = S_DIV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (MD_flush || (cnt_q == 5'd0)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        if (MD_flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and HI/LO updates per state; a flush suppresses every write.
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    sgn_d  = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (EX_MDOp)
            OP_MULT, OP_MULTU: begin
              a_d   = EX_RSData;
              b_d   = EX_RTData;
              sgn_d = (EX_MDOp == OP_MULT);
              cnt_d = MUL_CNT_INIT;
            end
            OP_DIV, OP_DIVU: begin
              a_d    = EX_RSData;
              b_d    = rt_abs_s;
              quot_d = rs_abs_s;
              rem_d  = 33'd0;
              qneg_d = (EX_MDOp == OP_DIV) && (EX_RSData[31] ^ EX_RTData[31]);
              rneg_d = (EX_MDOp == OP_DIV) && EX_RSData[31];
              cnt_d  = 5'd31;
            end
            OP_MTHI: hi_d = EX_RSData;
            OP_MTLO: lo_d = EX_RSData;
            default: cnt_d = cnt_q;
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_MUL: begin
        if (MD_flush) begin
          cnt_d = 5'd0;
        end else if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
      end
      S_DIV: begin
        if (MD_flush) begin
          cnt_d = 5'd0;
        end else begin
          rem_d  = ge_s ? diff_s : shift_s[32:0];
          quot_d = {quot_q[30:0], ge_s};
          cnt_d  = (cnt_q != 5'd0) ? (cnt_q - 5'd1) : 5'd0;
        end
      end
      S_FIX: begin
        if (MD_flush) begin
          cnt_d = 5'd0;
        end else if (b_q == 32'd0) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix_s;
          lo_d = quot_fix_s;
        end
      end
      default: cnt_d = 5'd0;
    endcase
  end

  // Busy mirrors the next state so it drops on the same edge HI/LO are written.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  assign isbusy = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized scoreboard bench for md_unit: driver pushes expected HI/LO and busy length,
// monitor pops and compares when each result is due.
module tb_md_unit;
  localparam int MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .EX_MDStart (start),
    .EX_MDOp    (op),
    .EX_RSData  (rs),
    .EX_RTData  (rt),
    .MD_flush   (flush),
    .isbusy     (busy),
    .HI         (hi),
    .LO         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: busy run tracking plus scoreboard pops on the due cycle.
  initial begin
    bit   prev_busy;
    int   rise_cyc;
    int   fall_cyc;
    int   meas;
    exp_t e;
    prev_busy = 1'b0;
    rise_cyc  = 0;
    fall_cyc  = -1;
    forever begin
      @(negedge clk);
      if ((busy === 1'b1) && !prev_busy) rise_cyc = cyc;
      if ((busy !== 1'b1) && prev_busy) fall_cyc = cyc;
      prev_busy = (busy === 1'b1);
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: result not seen, due cycle %0d now %0d", e.name, e.due, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        meas = (fall_cyc == cyc) ? (cyc - rise_cyc) : 0;
        chk({e.name, " HI"}, hi, e.hi);
        chk({e.name, " LO"}, lo, e.lo);
        chk({e.name, " busy_cycles"}, 32'(meas), 32'(e.lat));
        chk({e.name, " isbusy_after"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [2:0] o);
    case (o)
      3'd1, 3'd2: return MUL_CYCLES;
      3'd3, 3'd4: return 33;
      default:    return 0;
    endcase
  endfunction

  // Reference model: plain integer arithmetic on the architectural result.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, qq, rr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin qq = sa / sb; rr = sa % sb; m_lo = qq[31:0]; m_hi = rr[31:0]; end
      end
      3'd4: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: m_hi = m_hi;
    endcase
  endtask

  task automatic push(input string nm, input int due, input int lat,
                      input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.due = due; e.lat = lat; e.hi = eh; e.lo = el; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit fl, input string nm);
    int lat;
    start = 1'b1; op = o; rs = a; rt = b; flush = fl;
    lat = 0;
    if (!fl && o != 3'd0 && o != 3'd7) begin
      model(o, a, b);
      lat = lat_of(o);
    end
    push(nm, cyc + 1 + lat, lat, m_hi, m_lo);
    tick();
    start = 1'b0; flush = 1'b0;
    op = 3'($urandom); rs = $urandom; rt = $urandom;
    repeat (lat) tick();
  endtask

  task automatic abort_div(input logic [31:0] a, input logic [31:0] b, input int f,
                           input bit use_rst, input string nm);
    logic [31:0] eh, el;
    eh = use_rst ? 32'd0 : m_hi;
    el = use_rst ? 32'd0 : m_lo;
    start = 1'b1; op = 3'd3; rs = a; rt = b; flush = 1'b0;
    push(nm, cyc + 1 + f, f, eh, el);
    tick();
    start = 1'b0; rs = $urandom; rt = $urandom;
    repeat (f - 1) tick();
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    m_hi = eh; m_lo = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    push("reset", cyc, 0, 32'd0, 32'd0);
    tick();

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu_neg2x3");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
    issue(3'd4, 32'd100, 32'd7, 1'b0, "divu_100by7");
    issue(3'd4, 32'h0000_1234, 32'd0, 1'b0, "divu_by0");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_by_m1");
    issue(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, "mthi");
    issue(3'd6, 32'h5A5A_5A5A, 32'd0, 1'b0, "mtlo");
    issue(3'd5, 32'h1111_1111, 32'd0, 1'b1, "mthi_flushed");
    abort_div(32'd1000, 32'd3, 10, 1'b0, "div_flush_c10");
    issue(3'd1, 32'd7, 32'd6, 1'b0, "mult_after_flush");
    abort_div(32'd1000, 32'd3, 33, 1'b0, "div_flush_c33");
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    abort_div(32'd1000, 32'd3, 5, 1'b1, "div_rst_c5");
    issue(3'd3, 32'd9, 32'hFFFF_FFFD, 1'b0, "div_9by_m3");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        abort_div(pick(), pick(), $urandom_range(1, 33), 1'($urandom_range(0, 1)), "rand_abort");
      end else begin
        issue(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 7) == 0), "rand_op");
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    for (int k = 0; k < 100 && sb_q.size() > 0; k++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
